// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit core: addressing modes, instruction
// classes, sequencer states and default entry-sequence lengths.
package cpu_pkg;

  typedef enum logic [3:0] {
    IMPL = 4'd0,
    ACC  = 4'd1,
    IMM  = 4'd2,
    ZPG  = 4'd3,
    ZPGX = 4'd4,
    ZPGY = 4'd5,
    ABS  = 4'd6,
    ABSX = 4'd7,
    ABSY = 4'd8,
    IND  = 4'd9,
    XIND = 4'd10,
    INDY = 4'd11,
    REL  = 4'd12
  } addr_mode_t;

  typedef enum logic [3:0] {
    READ  = 4'd0,
    STORE = 4'd1,
    RMW   = 4'd2,
    JMP   = 4'd3,
    PUSH  = 4'd4,
    PULL  = 4'd5,
    BRK   = 4'd6,
    JSR   = 4'd7,
    RTI   = 4'd8,
    RTS   = 4'd9
  } op_class_t;

  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    INSTR   = 2'd1,
    INT_SEQ = 2'd2
  } seq_state_t;

  localparam int DEF_RST_LEN = 7;
  localparam int DEF_INT_LEN = 7;

endpackage

// File: rtl/cycle_len_lut.sv
// Instruction length table: mode/class -> base cycle count and the
// T-state (if any) at which a conditional extra cycle may be granted.
// Ports: mode, cls in; base_len, ext_t, ext_ok, is_rel out.
module cycle_len_lut
  import cpu_pkg::*;
(
  input  logic [3:0] mode,
  input  logic [3:0] cls,
  output logic [2:0] base_len,
  output logic [2:0] ext_t,
  output logic       ext_ok,
  output logic       is_rel
);

  addr_mode_t m;
  op_class_t  c;

  always_comb begin
    m = addr_mode_t'(mode);
    // reserved classes behave as reads
    c = (cls > 4'd9) ? READ : op_class_t'(cls);
    base_len = 3'd2;
    ext_t    = 3'd0;
    ext_ok   = 1'b0;
    is_rel   = 1'b0;
    case (c)
      BRK:  base_len = 3'd7;
      JSR:  base_len = 3'd6;
      RTI:  base_len = 3'd6;
      RTS:  base_len = 3'd6;
      PUSH: base_len = 3'd3;
      PULL: base_len = 3'd4;
      JMP: begin
        if (m == ABS)      base_len = 3'd3;
        else if (m == IND) base_len = 3'd5;
      end
      default: begin
        case (m)
          IMPL, ACC, IMM:
            base_len = 3'd2;
          ZPG:
            base_len = (c == RMW) ? 3'd5 : 3'd3;
          ZPGX, ZPGY, ABS:
            base_len = (c == RMW) ? 3'd6 : 3'd4;
          ABSX, ABSY: begin
            case (c)
              STORE: base_len = 3'd5;
              RMW:   base_len = 3'd7;
              default: begin
                base_len = 3'd4;
                ext_t    = 3'd3;
                ext_ok   = 1'b1;
              end
            endcase
          end
          XIND:
            base_len = 3'd6;
          INDY: begin
            if (c == READ) begin
              base_len = 3'd5;
              ext_t    = 3'd4;
              ext_ok   = 1'b1;
            end else if (c == STORE) begin
              base_len = 3'd6;
            end
          end
          REL: begin
            base_len = 3'd2;
            ext_t    = 3'd1;
            ext_ok   = 1'b1;
            is_rel   = 1'b1;
          end
          default: base_len = 3'd2;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// T-state timing generator: instruction cycles with page/branch
// extensions, plus reset and interrupt entry sequences.
// Ports: clk, rst, rdy, addr_mode, op_class, branch_taken, page_cross,
// irq_pend in; t_state, sync, last_cycle, rst_seq, int_seq, extended out.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int RST_LEN = DEF_RST_LEN,
  parameter int INT_LEN = DEF_INT_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [3:0] addr_mode,
  input  logic [3:0] op_class,
  input  logic       branch_taken,
  input  logic       page_cross,
  input  logic       irq_pend,
  output logic [2:0] t_state,
  output logic       sync,
  output logic       last_cycle,
  output logic       rst_seq,
  output logic       int_seq,
  output logic       extended
);

  seq_state_t state_q, state_d;
  logic [2:0] t_q, t_d;
  logic       sync_q, sync_d;
  logic       rseq_q, rseq_d;
  logic       iseq_q, iseq_d;
  logic       ext_q, ext_d;
  logic [1:0] extc_q, extc_d;
  logic [3:0] mode_q, mode_d;
  logic [3:0] cls_q, cls_d;

  logic [3:0] lut_mode;
  logic [3:0] lut_cls;
  logic [2:0] base_len;
  logic [2:0] ext_t;
  logic       ext_ok;
  logic       is_rel;
  logic       live_ext;
  logic [2:0] cur_len;

  // T1 decodes from the live decoder outputs; later cycles use the latch
  assign lut_mode = (t_q == 3'd1) ? addr_mode : mode_q;
  assign lut_cls  = (t_q == 3'd1) ? op_class : cls_q;

  cycle_len_lut u_lut (
    .mode     (lut_mode),
    .cls      (lut_cls),
    .base_len (base_len),
    .ext_t    (ext_t),
    .ext_ok   (ext_ok),
    .is_rel   (is_rel)
  );

  // second branch extension only exists once the branch was taken
  assign live_ext =
      (ext_ok && (t_q == ext_t) &&
       (is_rel ? branch_taken : page_cross)) ||
      (is_rel && (extc_q != 2'd0) &&
       (t_q == 3'd2) && page_cross);

  assign cur_len = base_len + {1'b0, extc_q} + {2'b00, live_ext};

  always_comb begin
    last_cycle = 1'b0;
    case (state_q)
      RST_SEQ: last_cycle = (t_q == 3'(RST_LEN - 1));
      INT_SEQ: last_cycle = (t_q == 3'(INT_LEN - 1));
      INSTR:   last_cycle = (t_q != 3'd0) &&
                            (t_q == cur_len - 3'd1);
      default: last_cycle = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    sync_d  = sync_q;
    rseq_d  = rseq_q;
    iseq_d  = iseq_q;
    ext_d   = ext_q;
    extc_d  = extc_q;
    mode_d  = mode_q;
    cls_d   = cls_q;
    if (rst) begin
      state_d = RST_SEQ;
      t_d     = 3'd0;
      sync_d  = 1'b0;
      rseq_d  = 1'b1;
      iseq_d  = 1'b0;
      ext_d   = 1'b0;
      extc_d  = 2'd0;
      mode_d  = 4'd0;
      cls_d   = 4'd0;
    end else if (rdy) begin
      case (state_q)
        RST_SEQ, INT_SEQ: begin
          if (last_cycle) begin
            state_d = INSTR;
            t_d     = 3'd0;
            sync_d  = 1'b1;
            rseq_d  = 1'b0;
            iseq_d  = 1'b0;
          end else begin
            t_d = t_q + 3'd1;
          end
        end
        INSTR: begin
          if (last_cycle) begin
            t_d    = 3'd0;
            ext_d  = 1'b0;
            extc_d = 2'd0;
            if (irq_pend) begin
              state_d = INT_SEQ;
              sync_d  = 1'b0;
              iseq_d  = 1'b1;
            end else begin
              sync_d = 1'b1;
            end
          end else begin
            t_d    = t_q + 3'd1;
            sync_d = 1'b0;
            if (t_q == 3'd1) begin
              mode_d = addr_mode;
              cls_d  = op_class;
            end
            if (live_ext) begin
              extc_d = extc_q + 2'd1;
              ext_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = RST_SEQ;
          t_d     = 3'd0;
          rseq_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    t_q     <= t_d;
    sync_q  <= sync_d;
    rseq_q  <= rseq_d;
    iseq_q  <= iseq_d;
    ext_q   <= ext_d;
    extc_q  <= extc_d;
    mode_q  <= mode_d;
    cls_q   <= cls_d;
  end

  assign t_state  = t_q;
  assign sync     = sync_q;
  assign rst_seq  = rseq_q;
  assign int_seq  = iseq_q;
  assign extended = ext_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues per-cycle
// expected outputs, a negedge monitor pops and compares them.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst, rdy, bt, pc, ip;
  logic [3:0] mode, cls;
  logic [2:0] t_state;
  logic       sync, last_cycle, rst_seq, int_seq, extended;

  typedef struct packed {
    logic [2:0] t;
    logic       s;
    logic       l;
    logic       r;
    logic       i;
    logic       x;
  } exp_t;

  typedef struct {
    string nm;
    exp_t  e;
  } item_t;

  item_t sbq[$];
  int    n_run  = 0;
  int    n_fail = 0;

  instr_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .addr_mode    (mode),
    .op_class     (cls),
    .branch_taken (bt),
    .page_cross   (pc),
    .irq_pend     (ip),
    .t_state      (t_state),
    .sync         (sync),
    .last_cycle   (last_cycle),
    .rst_seq      (rst_seq),
    .int_seq      (int_seq),
    .extended     (extended)
  );

  always #5 clk = ~clk;

  function automatic exp_t ev(int t, bit s, bit l,
                              bit r, bit i, bit x);
    exp_t e;
    e.t = 3'(t);
    e.s = s;
    e.l = l;
    e.r = r;
    e.i = i;
    e.x = x;
    return e;
  endfunction

  // monitor: compare every cycle that has an expectation queued
  always @(negedge clk) begin
    item_t it;
    exp_t  act;
    if (sbq.size() != 0) begin
      it  = sbq.pop_front();
      act = {t_state, sync, last_cycle, rst_seq, int_seq, extended};
      n_run++;
      if (act !== it.e) begin
        n_fail++;
        $display("FAIL %s: got t=%0d sync=%0b last=%0b rst_seq=%0b int_seq=%0b ext=%0b, required t=%0d sync=%0b last=%0b rst_seq=%0b int_seq=%0b ext=%0b",
                 it.nm, act.t, act.s, act.l, act.r, act.i, act.x,
                 it.e.t, it.e.s, it.e.l, it.e.r, it.e.i, it.e.x);
      end
    end
  end

  task automatic cyc(input string nm, input exp_t e);
    item_t it;
    it.nm = nm;
    it.e  = e;
    sbq.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // T0..T(n-1) of a plain instruction with no extension
  task automatic plain(input string nm, input int n);
    for (int k = 0; k < n; k++)
      cyc(nm, ev(k, k == 0, k == n - 1, 0, 0, 0));
  endtask

  initial begin
    rst  = 1'b1;
    rdy  = 1'b1;
    mode = 4'd0;
    cls  = 4'd0;
    bt   = 1'b0;
    pc   = 1'b0;
    ip   = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cyc("reset_hold", ev(0, 0, 0, 1, 0, 0));
    rst = 1'b0;
    ip  = 1'b1;
    for (int k = 0; k < 7; k++)
      cyc("rst_seq", ev(k, 0, k == 6, 1, 0, 0));
    ip = 1'b0;

    mode = 4'd7; cls = 4'd0;
    plain("absx_read", 4);

    for (int k = 0; k < 3; k++)
      cyc("absx_read_pc", ev(k, k == 0, 0, 0, 0, 0));
    pc = 1'b1;
    cyc("absx_read_pc_t3", ev(3, 0, 0, 0, 0, 0));
    pc = 1'b0;
    cyc("absx_read_pc_t4", ev(4, 0, 1, 0, 0, 1));

    cls = 4'd1; pc = 1'b1;
    plain("absx_store_pc", 5);
    pc = 1'b0;

    mode = 4'd12; cls = 4'd0;
    plain("rel_not_taken", 2);

    cyc("rel_taken_t0", ev(0, 1, 0, 0, 0, 0));
    bt = 1'b1;
    cyc("rel_taken_t1", ev(1, 0, 0, 0, 0, 0));
    bt = 1'b0;
    cyc("rel_taken_t2", ev(2, 0, 1, 0, 0, 1));

    cyc("rel_pc_t0", ev(0, 1, 0, 0, 0, 0));
    bt = 1'b1; pc = 1'b1;
    cyc("rel_pc_t1", ev(1, 0, 0, 0, 0, 0));
    bt = 1'b0;
    cyc("rel_pc_t2", ev(2, 0, 0, 0, 0, 1));
    pc = 1'b0;
    cyc("rel_pc_t3", ev(3, 0, 1, 0, 0, 1));

    mode = 4'd3; cls = 4'd2;
    cyc("zpg_rmw_t0", ev(0, 1, 0, 0, 0, 0));
    cyc("zpg_rmw_t1", ev(1, 0, 0, 0, 0, 0));
    rdy = 1'b0;
    repeat (3) cyc("zpg_rmw_wait", ev(2, 0, 0, 0, 0, 0));
    rdy = 1'b1;
    cyc("zpg_rmw_t2", ev(2, 0, 0, 0, 0, 0));
    cyc("zpg_rmw_t3", ev(3, 0, 0, 0, 0, 0));
    cyc("zpg_rmw_t4", ev(4, 0, 1, 0, 0, 0));

    mode = 4'd11; cls = 4'd0;
    for (int k = 0; k < 4; k++)
      cyc("indy_read_pc", ev(k, k == 0, 0, 0, 0, 0));
    pc = 1'b1;
    cyc("indy_read_pc_t4", ev(4, 0, 0, 0, 0, 0));
    pc = 1'b0;
    cyc("indy_read_pc_t5", ev(5, 0, 1, 0, 0, 1));

    mode = 4'd0; cls = 4'd6;
    plain("brk", 7);

    cls = 4'd0;
    cyc("irq_t0", ev(0, 1, 0, 0, 0, 0));
    ip = 1'b1;
    cyc("irq_t1", ev(1, 0, 1, 0, 0, 0));
    for (int k = 0; k < 7; k++)
      cyc("int_seq", ev(k, 0, k == 6, 0, 1, 0));
    ip = 1'b0;
    cyc("after_int", ev(0, 1, 0, 0, 0, 0));

    ip = 1'b1;
    cyc("irq2_t1", ev(1, 0, 1, 0, 0, 0));
    ip = 1'b0;
    for (int k = 0; k < 3; k++)
      cyc("int_seq2", ev(k, 0, 0, 0, 1, 0));
    rst = 1'b1;
    cyc("int_seq2_t3", ev(3, 0, 0, 0, 1, 0));
    rst = 1'b0;
    for (int k = 0; k < 7; k++)
      cyc("rst_from_int", ev(k, 0, k == 6, 1, 0, 0));
    cyc("after_rst", ev(0, 1, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
